// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: front-panel run/step controller for a simple CPU.
// Synchronizes and debounces the start/step pushbuttons, turns their
// presses into single-cycle pulses and sequences free-run and single-step
// execution. It also counts instruction fetches since the last start.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset, CPU not running, waiting for start
// RUN       | CPU enabled, counting fetch edges
// STEP_WAIT | single-step mode, fetch seen, waiting for step press
// HALTED    | control unit halted the CPU, count and mode frozen
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_btn_start,
  input  logic                   i_btn_step,
  input  logic                   i_mode_step,
  input  logic                   i_if_stage,
  input  logic                   i_cpu_halt,
  output logic                   o_cpu_start,
  output logic                   o_step_execution,
  output logic                   o_next_instr_stimulus,
  output logic [1:0]             o_state,
  output logic [COUNT_WIDTH-1:0] o_instr_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    HALTED    = 2'b11
  } state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // bit 0 = start button, bit 1 = step button, bit 2 = mode switch
  logic [2:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_d;
  logic [1:0]     pulse_q, pulse_d;
  logic [DBW-1:0] cnt_q [2];
  logic [DBW-1:0] cnt_d [2];

  state_t                 state_q, state_d;
  logic                   cpu_start_q, cpu_start_d;
  logic                   step_exec_q, step_exec_d;
  logic                   stim_q, stim_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   if_prev_q;

  logic start_p, step_p, if_edge;

  assign start_p = pulse_q[0];
  assign step_p  = pulse_q[1];
  assign if_edge = i_if_stage & ~if_prev_q;

  // Two-flop synchronizers for the raw asynchronous panel inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i_mode_step, i_btn_step, i_btn_start};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches;
  // a rising acceptance also fires the one-cycle press pulse.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_d[k]   = deb_q[k];
      cnt_d[k]   = '0;
      pulse_d[k] = 1'b0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          deb_d[k]   = sync2_q[k];
          pulse_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + DBW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_q    <= '0;
      pulse_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      deb_q    <= deb_d;
      pulse_q  <= pulse_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Next-state and registered-output logic; halt outranks step and fetch
  always_comb begin
    state_d     = state_q;
    step_exec_d = step_exec_q;
    count_d     = count_q;
    stim_d      = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start_p) begin
          state_d     = RUN;
          step_exec_d = sync2_q[2];
          count_d     = '0;
        end
      end
      RUN: begin
        if (i_cpu_halt) begin
          state_d = HALTED;
        end else if (if_edge) begin
          if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
          if (step_exec_q) state_d = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        if (i_cpu_halt) begin
          state_d = HALTED;
        end else if (step_p) begin
          stim_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    cpu_start_d = (state_d == RUN) || (state_d == STEP_WAIT);
  end

  // FSM state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cpu_start_q <= 1'b0;
      step_exec_q <= 1'b0;
      stim_q      <= 1'b0;
      count_q     <= '0;
      if_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_start_q <= cpu_start_d;
      step_exec_q <= step_exec_d;
      stim_q      <= stim_d;
      count_q     <= count_d;
      if_prev_q   <= i_if_stage;
    end
  end

  assign o_state               = state_q;
  assign o_cpu_start           = cpu_start_q;
  assign o_step_execution      = step_exec_q;
  assign o_next_instr_stimulus = stim_q;
  assign o_instr_count         = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4.
// A second instance with a 4-bit counter shares all inputs for saturation.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0, btn_step = 1'b0, mode_step = 1'b0;
  logic        if_stage = 1'b0, cpu_halt = 1'b0;
  logic        cpu_start, step_exec, stim;
  logic [1:0]  state;
  logic [15:0] count;
  logic        cpu_start4, step_exec4, stim4;
  logic [1:0]  state4;
  logic [3:0]  count4;

  int checks = 0;
  int errors = 0;
  int stim_cnt = 0;
  logic stim_prev = 1'b0;
  logic stim_double = 1'b0;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_start(btn_start), .i_btn_step(btn_step),
    .i_mode_step(mode_step), .i_if_stage(if_stage), .i_cpu_halt(cpu_halt),
    .o_cpu_start(cpu_start), .o_step_execution(step_exec),
    .o_next_instr_stimulus(stim), .o_state(state), .o_instr_count(count)
  );

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn_start(btn_start), .i_btn_step(btn_step),
    .i_mode_step(mode_step), .i_if_stage(if_stage), .i_cpu_halt(cpu_halt),
    .o_cpu_start(cpu_start4), .o_step_execution(step_exec4),
    .o_next_instr_stimulus(stim4), .o_state(state4), .o_instr_count(count4)
  );

  always #5 clk = ~clk;

  // Count stimulus pulses and flag any two-cycle-wide pulse
  always @(negedge clk) begin
    if (stim) stim_cnt <= stim_cnt + 1;
    if (stim && stim_prev) stim_double <= 1'b1;
    stim_prev <= stim;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start(input int hold);
    btn_start = 1'b1;
    tick(hold);
    btn_start = 1'b0;
    tick(10);
  endtask

  task automatic press_step(input int hold);
    btn_step = 1'b1;
    tick(hold);
    btn_step = 1'b0;
    tick(10);
  endtask

  task automatic fetch();
    if_stage = 1'b1;
    tick(1);
    if_stage = 1'b0;
    tick(1);
  endtask

  initial begin
    int stim_before;
    tick(3);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_outs", {28'h0, cpu_start, step_exec, stim, 1'b0}, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // free-run start, three fetches
    mode_step = 1'b0;
    press_start(10);
    chk("run_state", 32'(state), 32'h1);
    chk("run_cpu_start", 32'(cpu_start), 32'h1);
    chk("run_step_exec", 32'(step_exec), 32'h0);
    repeat (3) fetch();
    chk("run_count3", 32'(count), 32'd3);
    press_start(10);
    chk("start_in_run_ignored", 32'(count), 32'd3);
    repeat (2) fetch();
    chk("run_count5", 32'(count), 32'd5);

    // asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_outs", {29'h0, cpu_start, step_exec, stim}, 32'h0);
    chk("midrst_count", 32'(count), 32'h0);
    tick(2);
    rst_n = 1'b1;
    stim_before = stim_cnt;
    tick(10);
    chk("postrst_state", 32'(state), 32'h0);
    chk("postrst_nostim", 32'(stim_cnt), 32'(stim_before));

    // bouncing start button never settles long enough
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      tick(2);
    end
    btn_start = 1'b0;
    tick(10);
    chk("bounce_state", 32'(state), 32'h0);
    chk("bounce_cpu_start", 32'(cpu_start), 32'h0);

    // single-step mode
    mode_step = 1'b1;
    press_start(8);
    chk("step_run_state", 32'(state), 32'h1);
    chk("step_exec_latched", 32'(step_exec), 32'h1);
    chk("step_count0", 32'(count), 32'h0);
    fetch();
    chk("stepwait_state", 32'(state), 32'h2);
    chk("stepwait_count", 32'(count), 32'd1);
    stim_before = stim_cnt;
    press_step(8);
    chk("step_stim_once", 32'(stim_cnt), 32'(stim_before + 1));
    chk("step_back_run", 32'(state), 32'h1);
    press_step(8);
    chk("step_in_run_discard", 32'(stim_cnt), 32'(stim_before + 1));
    chk("step_in_run_state", 32'(state), 32'h1);
    fetch();
    chk("stepwait2_state", 32'(state), 32'h2);
    chk("stepwait2_count", 32'(count), 32'd2);

    // halt in the same cycle as the step pulse
    stim_before = stim_cnt;
    btn_step = 1'b1;
    tick(6);
    cpu_halt = 1'b1;
    tick(1);
    cpu_halt = 1'b0;
    btn_step = 1'b0;
    tick(1);
    chk("halt_state", 32'(state), 32'h3);
    chk("halt_cpu_start", 32'(cpu_start), 32'h0);
    tick(10);
    chk("halt_nostim", 32'(stim_cnt), 32'(stim_before));
    chk("halt_count_held", 32'(count), 32'd2);
    chk("halt_mode_held", 32'(step_exec), 32'h1);
    press_start(8);
    chk("restart_state", 32'(state), 32'h1);
    chk("restart_count", 32'(count), 32'h0);

    // halt from RUN, restart free-run, saturate the 4-bit counter
    cpu_halt = 1'b1;
    tick(1);
    cpu_halt = 1'b0;
    tick(1);
    chk("halt_from_run", 32'(state), 32'h3);
    mode_step = 1'b0;
    press_start(8);
    chk("fr_state", 32'(state), 32'h1);
    chk("fr_step_exec", 32'(step_exec), 32'h0);
    repeat (20) fetch();
    chk("count20", 32'(count), 32'd20);
    chk("sat_count4", 32'(count4), 32'hF);
    chk("sat_state4", 32'(state4), 32'h1);
    chk("stim_never_double", 32'(stim_double), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
